// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backend memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed data priority.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no transaction; grants a new request when be_done is low
// BUSY_D | backend working for the data port; timeout counter running
// BUSY_I | backend working for the fetch port; timeout counter running
// RESP   | one-cycle ack to the granted port; rdata already captured
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [17:0] if_addr,
  output logic        if_ack,
  output logic [15:0] if_rdata,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [17:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        hold,
  output logic        be_need_to_work,
  output logic        be_rd,
  output logic        be_wr,
  output logic [17:0] be_addr,
  output logic [15:0] be_wdata,
  input  logic        be_done,
  input  logic [15:0] be_result,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Last busy cycle index; the counter starts at 0 on the first BUSY cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic        op_wr_q;
  logic        resp_d_q;
  logic        err_q;

  logic        d_req;
  logic        any_req;
  logic        grant;
  logic        pick_d;
  logic        busy;
  logic        cnt_done;
  logic        finish;

  assign d_req    = d_rd | d_wr;
  assign any_req  = d_req | if_req;
  assign grant    = (state_q == IDLE) && any_req && !be_done;
  assign busy     = (state_q == BUSY_D) || (state_q == BUSY_I);
  assign cnt_done = (cnt_q == CNT_LAST);
  assign finish   = busy && (be_done || cnt_done);

`ifdef MEM_ARB_RR_EN
  // Pointer set means the data port holds the most recent grant.
  logic last_d_q;

  assign pick_d = d_req && (!if_req || !last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b1;
    end else if (grant) begin
      last_d_q <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = pick_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_D, BUSY_I: begin
        if (be_done || cnt_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    be_need_to_work = 1'b0;
    be_rd           = 1'b0;
    be_wr           = 1'b0;
    if_ack          = 1'b0;
    d_ack           = 1'b0;
    case (state_q)
      BUSY_D, BUSY_I: begin
        be_need_to_work = 1'b1;
        be_rd           = !op_wr_q;
        be_wr           = op_wr_q;
      end
      RESP: begin
        d_ack  = resp_d_q;
        if_ack = !resp_d_q;
      end
      default: begin
      end
    endcase
  end

  // Backend command is captured at grant and left untouched until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      be_addr  <= '0;
      be_wdata <= '0;
      op_wr_q  <= 1'b0;
      resp_d_q <= 1'b0;
    end else if (grant) begin
      be_addr  <= pick_d ? d_addr : if_addr;
      be_wdata <= pick_d ? d_wdata : '0;
      op_wr_q  <= pick_d && d_wr;
      resp_d_q <= pick_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (grant) begin
      cnt_q <= '0;
    end else if (busy && !finish) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // A real completion wins over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
      err_q    <= 1'b0;
    end else if (finish) begin
      if (state_q == BUSY_D) begin
        d_rdata <= be_done ? be_result : 16'hFFFF;
      end else begin
        if_rdata <= be_done ? be_result : 16'hFFFF;
      end
      if (!be_done) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err  = err_q;
  assign hold = (d_req & ~d_ack) | (if_req & ~if_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT_CYCLES=4); inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [17:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_rd;
  logic        d_wr;
  logic [17:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        hold;
  logic        be_need_to_work;
  logic        be_rd;
  logic        be_wr;
  logic [17:0] be_addr;
  logic [15:0] be_wdata;
  logic        be_done;
  logic [15:0] be_result;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .hold(hold),
    .be_need_to_work(be_need_to_work), .be_rd(be_rd), .be_wr(be_wr),
    .be_addr(be_addr), .be_wdata(be_wdata),
    .be_done(be_done), .be_result(be_result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a grant, checks the backend command, completes it and checks the ack.
  task automatic serve(input string tag, input logic exp_d, input logic exp_wr,
                       input logic [17:0] exp_addr, input logic [15:0] exp_wdata,
                       input logic [15:0] result);
    int n = 0;
    while (!be_need_to_work && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant"}, 32'(be_need_to_work), 32'd1);
    chk({tag, "_be_wr"}, 32'(be_wr), 32'(exp_wr));
    chk({tag, "_be_rd"}, 32'(be_rd), 32'(!exp_wr));
    chk({tag, "_be_addr"}, 32'(be_addr), 32'(exp_addr));
    if (exp_wr) chk({tag, "_be_wdata"}, 32'(be_wdata), 32'(exp_wdata));
    be_done   = 1'b1;
    be_result = result;
    @(negedge clk);
    chk({tag, "_d_ack"}, 32'(d_ack), 32'(exp_d));
    chk({tag, "_if_ack"}, 32'(if_ack), 32'(!exp_d));
    if (exp_d && !exp_wr) chk({tag, "_d_rdata"}, 32'(d_rdata), 32'(result));
    if (!exp_d) chk({tag, "_if_rdata"}, 32'(if_rdata), 32'(result));
    if (exp_d) begin
      d_rd = 1'b0;
      d_wr = 1'b0;
    end else begin
      if_req = 1'b0;
    end
    be_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; be_done = 1'b0; be_result = '0;
    repeat (2) @(negedge clk);
    chk("rst_be_need", 32'(be_need_to_work), 32'd0);
    chk("rst_be_addr", 32'(be_addr), 32'd0);
    chk("rst_acks", 32'({if_ack, d_ack, be_rd, be_wr, err}), 32'd0);
    chk("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Data read, be_done in the third busy cycle.
    d_rd = 1'b1; d_addr = 18'h00100;
    #1;
    chk("rd_hold_req", 32'(hold), 32'd1);
    chk("rd_no_work_yet", 32'(be_need_to_work), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_busy_work", 32'(be_need_to_work), 32'd1);
      chk("rd_busy_cmd", 32'({be_rd, be_wr}), 32'b10);
      chk("rd_busy_addr", 32'(be_addr), 32'h00100);
      chk("rd_busy_ack", 32'(d_ack), 32'd0);
      chk("rd_busy_hold", 32'(hold), 32'd1);
      if (k == 2) begin
        be_done = 1'b1; be_result = 16'hBEEF;
      end
    end
    @(negedge clk);
    chk("rd_ack", 32'(d_ack), 32'd1);
    chk("rd_rdata", 32'(d_rdata), 32'hBEEF);
    chk("rd_ack_hold", 32'(hold), 32'd0);
    chk("rd_resp_idle_be", 32'({be_need_to_work, be_rd, be_wr}), 32'd0);
    d_rd = 1'b0; be_done = 1'b0;
    @(negedge clk);
    chk("rd_after_ack", 32'(d_ack), 32'd0);
    chk("rd_after_hold", 32'(hold), 32'd0);
    chk("rd_rdata_kept", 32'(d_rdata), 32'hBEEF);

    // Simultaneous fetch and data write; previous grant was data.
    if_req = 1'b1; if_addr = 18'h00200;
    d_wr = 1'b1; d_addr = 18'h00300; d_wdata = 16'h1234;
`ifdef MEM_ARB_RR_EN
    serve("sim_if", 1'b0, 1'b0, 18'h00200, 16'h0000, 16'h5A5A);
    chk("sim_hold_d", 32'(hold), 32'd1);
    serve("sim_d", 1'b1, 1'b1, 18'h00300, 16'h1234, 16'h0000);
`else
    serve("sim_d", 1'b1, 1'b1, 18'h00300, 16'h1234, 16'h0000);
    chk("sim_hold_if", 32'(hold), 32'd1);
    serve("sim_if", 1'b0, 1'b0, 18'h00200, 16'h0000, 16'h5A5A);
`endif

    // Read and write together is a write.
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 18'h00400; d_wdata = 16'hABCD;
    serve("rdwr", 1'b1, 1'b1, 18'h00400, 16'hABCD, 16'h0000);

    // Backend never answers: four busy cycles then timeout.
    if_req = 1'b1; if_addr = 18'h00500;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_busy", 32'(be_need_to_work), 32'd1);
      chk("to_no_ack", 32'(if_ack), 32'd0);
    end
    @(negedge clk);
    chk("to_ack", 32'(if_ack), 32'd1);
    chk("to_rdata", 32'(if_rdata), 32'hFFFF);
    chk("to_err", 32'(err), 32'd1);
    chk("to_be_idle", 32'(be_need_to_work), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("to_err_sticky", 32'(err), 32'd1);

    // be_done stuck high after a completion blocks further grants.
    d_rd = 1'b1; d_addr = 18'h00600;
    @(negedge clk);
    chk("stuck_busy", 32'(be_need_to_work), 32'd1);
    be_done = 1'b1; be_result = 16'h1111;
    @(negedge clk);
    chk("stuck_ack", 32'(d_ack), 32'd1);
    chk("stuck_rdata", 32'(d_rdata), 32'h1111);
    d_rd = 1'b0; if_req = 1'b1; if_addr = 18'h00680;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stuck_no_grant", 32'(be_need_to_work), 32'd0);
      chk("stuck_hold", 32'(hold), 32'd1);
    end
    be_done = 1'b0;
    serve("stuck_rel", 1'b0, 1'b0, 18'h00680, 16'h0000, 16'h2222);
    chk("err_still", 32'(err), 32'd1);

    // Asynchronous reset in the middle of a data transaction.
    d_rd = 1'b1; d_addr = 18'h00700;
    @(negedge clk);
    chk("mid_busy", 32'(be_need_to_work), 32'd1);
    if_req = 1'b1; if_addr = 18'h00800;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_be", 32'({be_need_to_work, be_rd, be_wr}), 32'd0);
    chk("mid_rst_addr", 32'(be_addr), 32'd0);
    chk("mid_rst_err", 32'({err, d_ack, if_ack}), 32'd0);
    chk("mid_rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
    d_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    serve("post_rst", 1'b0, 1'b0, 18'h00800, 16'h0000, 16'h3C3C);
    chk("post_rst_hold", 32'(hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
